// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: DIGIT bits per clock, LSB first.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output ovf.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_addsub: DIGIT must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] opa, opb, res, res_n;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dsum;
  logic             accept, last;

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == LAST);

  always_comb begin
    c    = '0;
    dsum = '0;
    c[0] = cy;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]  = opa[i] ^ opb[i] ^ c[i];
      c[i+1]   = (opa[i] & opb[i]) | (opb[i] & c[i]) | (c[i] & opa[i]);
    end
  end

  // New digit enters at the top; after N digits the LSB lands in bit 0.
  assign res_n = (res >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (cnt == LAST) state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa       <= '0;
      opb       <= '0;
      res       <= '0;
      cnt       <= '0;
      cy        <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (accept) begin
      opa <= a;
      opb <= mode ? ~b : b;
      cy  <= mode;
      cnt <= '0;
    end else if (state == RUN) begin
      opa <= opa >> DIGIT;
      opb <= opb >> DIGIT;
      res <= res_n;
      cy  <= c[DIGIT];
      cnt <= cnt + CW'(1);
      if (last) begin
        sum       <= res_n;
        carry_out <= c[DIGIT];
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf       <= c[DIGIT] ^ c[DIGIT-1];
`endif
      end
    end
  end

endmodule
